// File: rtl/fpu_rnd_pkg.sv
// Shared definitions for the rounder's normalize/denormalize shifter.
// Holds default widths, the shifter FSM state encoding and a helper for
// sizing the remaining-shift counter.
package fpu_rnd_pkg;

  localparam int W_DEF    = 58;  // significand width
  localparam int SHW_DEF  = 13;  // shift distance / exponent width
  localparam int STEP_DEF = 8;   // max shift positions per cycle

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must hold 0..w inclusive (mag is clamped to w).
  function automatic int rem_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int REM_W_DEF = rem_width(W_DEF);

endpackage

// File: rtl/norm_shift_seq_if.sv
// Valid/ready bundle between shift-distance logic, the shifter and the
// round-increment stage.
//   in_valid/in_ready  : operand handshake (f_in, sh, er)
//   out_valid/out_ready: result handshake (f_out, sticky, eout)
// master = producer/consumer side (testbench / neighbours), slave = shifter.
interface norm_shift_seq_if #(
  parameter int W   = 58,
  parameter int SHW = 13
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   f_in;
  logic [SHW-1:0] sh;
  logic [SHW-1:0] er;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   f_out;
  logic           sticky;
  logic [SHW-1:0] eout;

  modport master (
    output in_valid, f_in, sh, er, out_ready,
    input  in_ready, out_valid, f_out, sticky, eout
  );

  modport slave (
    input  in_valid, f_in, sh, er, out_ready,
    output in_ready, out_valid, f_out, sticky, eout
  );
endinterface

// File: rtl/norm_shift_seq_shift_step.sv
// Combinational single-step shifter.
//   word    : W-bit input word
//   k       : shift amount, 0..STEP
//   dir     : 1 = right shift, 0 = left shift (zero fill both ways)
//   res     : shifted word
//   dropped : OR of the bits shifted out of the word
module shift_step #(
  parameter int W  = 58,
  parameter int KW = 4
) (
  input  logic [W-1:0]  word,
  input  logic [KW-1:0] k,
  input  logic          dir,
  output logic [W-1:0]  res,
  output logic          dropped
);

  logic [W-1:0] ones;
  logic [W-1:0] lo_mask;
  logic [W-1:0] hi_mask;

  // Shift and collect the bits that fall off the chosen end.
  always_comb begin
    ones    = '1;
    lo_mask = ~(ones << k);  // k LSBs, lost on a right shift
    hi_mask = ~(ones >> k);  // k MSBs, lost on a left shift
    if (dir) begin
      res     = word >> k;
      dropped = |(word & lo_mask);
    end else begin
      res     = word << k;
      dropped = |(word & hi_mask);
    end
  end

endmodule

// File: rtl/norm_shift_seq.sv
// Iterative significand normalize/denormalize shifter.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of norm_shift_seq_if
// Accepts f_in/sh/er in IDLE, shifts at most STEP positions per cycle in
// SHIFT (left for sh>0, right for sh<0, sticky collected on right shifts),
// and presents f_out/sticky/eout = er - sh in DONE until out_ready.
module norm_shift_seq
  import fpu_rnd_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int SHW  = SHW_DEF,
  parameter int STEP = STEP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  norm_shift_seq_if.slave bus
);

  localparam int RW = rem_width(W);
  localparam int KW = $clog2(STEP + 1);

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    work;
  logic            dir;
  logic [RW-1:0]   rem;
  logic            sticky_q;
  logic [SHW-1:0]  eout_q;

  logic [SHW:0]    sh_ext;
  logic [SHW:0]    sh_abs;
  logic [SHW:0]    mag_full;
  logic [RW-1:0]   mag;
  logic [KW-1:0]   k;
  logic [W-1:0]    step_res;
  logic            step_dropped;

  // Magnitude of sh in SHW+1 bits so the most negative value is exact,
  // then clamp to W since shifting further cannot change the result.
  always_comb begin
    sh_ext   = {bus.sh[SHW-1], bus.sh};
    sh_abs   = bus.sh[SHW-1] ? (~sh_ext + {{SHW{1'b0}}, 1'b1}) : sh_ext;
    mag_full = (sh_abs >= (SHW+1)'(W)) ? (SHW+1)'(W) : sh_abs;
    mag      = RW'(mag_full);
  end

  // Per-cycle shift amount: whatever remains, capped at STEP.
  always_comb begin
    if (rem > RW'(STEP)) begin
      k = KW'(STEP);
    end else begin
      k = KW'(rem);
    end
  end

  shift_step #(
    .W  (W),
    .KW (KW)
  ) u_shift_step (
    .word    (work),
    .k       (k),
    .dir     (dir),
    .res     (step_res),
    .dropped (step_dropped)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = (mag != '0) ? SHIFT : DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (rem == RW'(k)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake flags decoded from the registered state.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture on accept, one shift step per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work     <= '0;
      dir      <= 1'b0;
      rem      <= '0;
      sticky_q <= 1'b0;
      eout_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work     <= bus.f_in;
            dir      <= bus.sh[SHW-1];
            rem      <= mag;
            sticky_q <= 1'b0;
            eout_q   <= bus.er - bus.sh;  // wraps modulo 2^SHW
          end
        end
        SHIFT: begin
          work     <= step_res;
          rem      <= rem - RW'(k);
          // Bits leaving the MSB on a left shift are simply discarded.
          sticky_q <= sticky_q | (step_dropped & dir);
        end
        default: begin
          work <= work;
        end
      endcase
    end
  end

  assign bus.f_out  = work;
  assign bus.sticky = sticky_q;
  assign bus.eout   = eout_q;

endmodule

// File: tb/tb_norm_shift_seq.sv
module tb_norm_shift_seq;

  localparam int W   = 58;
  localparam int SHW = 13;

  typedef struct {
    logic [W-1:0]   f;
    logic [SHW-1:0] sh;
    logic [SHW-1:0] er;
    logic [W-1:0]   ef;
    logic           es;
    logic [SHW-1:0] ee;
    int             lat;
  } vec_t;

  typedef struct {
    logic [W-1:0]   ef;
    logic           es;
    logic [SHW-1:0] ee;
    int             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[11];
  exp_t sb[$];

  always #5 clk = ~clk;

  norm_shift_seq_if #(.W(W), .SHW(SHW)) bus ();

  norm_shift_seq #(.W(W), .SHW(SHW), .STEP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one operand, wait for the result, compare against the scoreboard.
  // hold: cycles to keep out_ready low in DONE while checking stability.
  task automatic run_op(input vec_t v, input int hold);
    exp_t e;
    int lat;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_op", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.f_in = v.f;
    bus.sh = v.sh;
    bus.er = v.er;
    sb.push_back('{ef: v.ef, es: v.es, ee: v.ee, lat: v.lat});
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.f_in = '0;
    bus.sh = '0;
    bus.er = '0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("latency", 64'(lat), 64'(e.lat));
    chk("f_out", 64'(bus.f_out), 64'(e.ef));
    chk("sticky", 64'(bus.sticky), 64'(e.es));
    chk("eout", 64'(bus.eout), 64'(e.ee));
    chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_f_out", 64'(bus.f_out), 64'(e.ef));
      chk("hold_sticky", 64'(bus.sticky), 64'(e.es));
      chk("hold_eout", 64'(bus.eout), 64'(e.ee));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    //           f_in                  sh        er        f_out           stk   eout      lat
    vecs[0]  = '{58'h1,                13'd5,    13'd100,  58'h20,         1'b0, 13'd95,   2};
    vecs[1]  = '{58'h3FFFF,            13'h1FEC, 13'd100,  58'h0,          1'b1, 13'd120,  4};
    vecs[2]  = '{58'h100,              13'h1FF8, 13'd0,    58'h1,          1'b0, 13'd8,    2};
    vecs[3]  = '{58'h100,              13'd0,    13'd7,    58'h100,        1'b0, 13'd7,    1};
    vecs[4]  = '{58'h200_0000_0000_0001, 13'h1F9C, 13'd0,  58'h0,          1'b1, 13'd100,  9};
    vecs[5]  = '{58'h3FF_FFFF_FFFF_FFFF, 13'd60, 13'd10,   58'h0,          1'b0, 13'h1FCE, 9};
    vecs[6]  = '{58'h0,                13'h1FFD, 13'd5,    58'h0,          1'b0, 13'd8,    2};
    vecs[7]  = '{58'h1,                13'h1000, 13'd0,    58'h0,          1'b1, 13'h1000, 9};
    vecs[8]  = '{58'h2D,               13'h1FFD, 13'd3,    58'h5,          1'b1, 13'd6,    2};
    vecs[9]  = '{58'h3,                13'd9,    13'd20,   58'h600,        1'b0, 13'd11,   3};
    vecs[10] = '{58'h2,                13'h1FFF, 13'h0FFF, 58'h1,          1'b0, 13'h1000, 2};

    bus.in_valid = 1'b0;
    bus.f_in = '0;
    bus.sh = '0;
    bus.er = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_f_out", 64'(bus.f_out), 64'd0);
    chk("rst_sticky", 64'(bus.sticky), 64'd0);
    chk("rst_eout", 64'(bus.eout), 64'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i], 0);
    end

    // Backpressure: hold out_ready low for 5 cycles in DONE.
    run_op(vecs[1], 5);

    // Reset mid-SHIFT, with in_valid left high during the shift.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.f_in = vecs[4].f;
    bus.sh = vecs[4].sh;
    bus.er = vecs[4].er;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_shift_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_f_out", 64'(bus.f_out), 64'd0);
    chk("mid_rst_eout", 64'(bus.eout), 64'd0);
    sb.delete();
    run_op(vecs[0], 0);
    run_op(vecs[8], 0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/norm_shift_seq.md
Name: norm_shift_seq

Overview:
- Iterative significand normalize/denormalize shifter for the rounder.
- Consumes the signed 13-bit shift distance produced by the rounder's shift-distance logic:
  - positive sh = left shift (normalization by leading-zero count);
  - negative sh = right shift (denormalization of tiny results).
- Shifts at most STEP positions per cycle, collects a sticky bit on right shifts, and adjusts the exponent.
- Sits between shift-distance computation and the round-increment stage, with valid/ready on both sides.

Parameters:
- W, 58, significand width in bits.
- SHW, 13, width of shift distance and exponent (two's complement).
- STEP, 8, maximum shift positions per cycle (power of two, 1..W).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- f_in  input  W  significand to shift.
- sh  input  SHW  signed shift distance; >0 left, <0 right.
- er  input  SHW  exponent before shift.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- f_out  output  W  shifted significand.
- sticky  output  1  OR of all 1-bits shifted out on the right.
- eout  output  SHW  er - sh, modulo 2^SHW.

Behaviour:
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Reset (rst_n low at a clock edge), from any state:
  - state=IDLE; f_out, sticky and eout = 0; internal counters = 0.
  - out_valid=0 and in_ready=1 from the following cycle.
  - An operation in progress is discarded.
- Accept edge (IDLE and in_valid):
  - Latch f_in into the working register.
  - Compute eout = er - sh and latch it.
  - Latch direction = sh[SHW-1] and mag = min(|sh|, W); |sh| uses SHW+1-bit arithmetic so sh = -4096 is handled.
  - Clear sticky.
  - Next state: SHIFT if mag>0, else DONE.
- SHIFT, each edge:
  - k = min(remaining, STEP); shift the working register by k in the latched direction, zero-filling.
  - Right shift: sticky |= OR of the k bits dropped. Left shift: bits dropped off the MSB are discarded; no flag.
  - remaining -= k. When remaining reaches 0, next state is DONE.
- Latency: N+1 edges from accept edge to out_valid high, where N = ceil(mag/STEP).
- DONE:
  - f_out, sticky and eout are held stable while out_ready is low.
  - out_valid and out_ready → IDLE on that edge.
  - A new operand is accepted no earlier than the following cycle; back-to-back throughput is N+2 cycles per op.
- Clamping:
  - |sh| >= W right: f_out=0, sticky = OR(f_in).
  - |sh| >= W left: f_out=0.
  - eout is always er - sh unclamped, wrapping modulo 2^SHW.
- f_in=0: result 0, sticky 0, normal latency.
- Inputs are ignored in SHIFT and DONE; in_valid may stay high without effect.

Decomposition:
- Package fpu_rnd_pkg holds:
  - W, SHW and STEP defaults;
  - the state enum (IDLE, SHIFT, DONE);
  - a helper constant for the remaining-counter width, clog2(W+1).
- One sub-module, shift_step: combinational shift of a W-bit word by k in 0..STEP, left or right, returning the shifted word and the OR of dropped bits. It is instantiated once in the SHIFT datapath.

Test Plan:
- Left shift: f_in=1, sh=+5, er=100 → f_out=0x20, sticky=0, eout=95, out_valid 2 edges after accept.
- Right shift, all bits lost: f_in=0x3FFFF, sh=-20 (13'h1FEC), er=100 → f_out=0, sticky=1, eout=120, latency 4 edges (N=3).
- Exact right shift at a STEP boundary: f_in=0x100, sh=-8 → f_out=1, sticky=0, latency 2. Repeat with sh=0 → f_out=f_in, latency 1.
- Clamp: f_in=58'h200_0000_0000_0001, sh=-100, er=0 → f_out=0, sticky=1, eout=100, latency 9 (N=8).
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → f_out, sticky and eout stable, in_ready=0.
  - Then assert out_ready → IDLE next edge.
  - Separately, drop rst_n for one edge mid-SHIFT → out_valid=0, in_ready=1 afterwards; the next operand completes correctly.
